// File: rtl/adder_sum_accumulator.sv
// Accumulates {overflow, sum} samples from the adder stage into blocks of NUM_SAMPLES.
// Optional saturating accumulation: define ADDER_SUM_ACC_SATURATE_EN.
module adder_sum_accumulator #(
   parameter int unsigned SUM_BITS    = 16,
   parameter int unsigned ACC_BITS    = 24,
   parameter int unsigned NUM_SAMPLES = 8
) (
   input  logic                             clk,
   input  logic                             n_rst,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [SUM_BITS-1:0]              sum,
   input  logic                             overflow,
   input  logic                             clear,
   output logic [ACC_BITS-1:0]              acc_out,
   output logic [$clog2(NUM_SAMPLES):0]     ovf_count,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic                             sat_flag
);

   localparam int unsigned CNT_BITS = $clog2(NUM_SAMPLES) + 1;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DONE
   } state_t;

   state_t              state_q, state_d;
   logic [ACC_BITS-1:0] acc_q, acc_d;
   logic [CNT_BITS-1:0] ovf_q, ovf_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;
   logic                sat_q, sat_d;
   logic [ACC_BITS-1:0] sample;
   logic                accept;

`ifdef ADDER_SUM_ACC_SATURATE_EN
   logic [ACC_BITS:0]   sum_ext;
   assign sum_ext = {1'b0, acc_q} + {1'b0, sample};
`endif

   assign sample    = ACC_BITS'({overflow, sum});
   assign in_ready  = (state_q != DONE);
   assign out_valid = (state_q == DONE);
   assign accept    = in_valid && in_ready;
   assign acc_out   = acc_q;
   assign ovf_count = ovf_q;
   assign sat_flag  = sat_q;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      sat_d   = sat_q;
      if (clear) begin
         state_d = IDLE;
         acc_d   = '0;
         ovf_d   = '0;
         cnt_d   = '0;
         sat_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE, ACCUM: begin
               if (accept) begin
`ifdef ADDER_SUM_ACC_SATURATE_EN
                  // Once saturated the accumulator is all ones, so any further
                  // nonzero sample carries out and keeps it pinned there.
                  if (sum_ext[ACC_BITS]) begin
                     acc_d = '1;
                     sat_d = 1'b1;
                  end else begin
                     acc_d = sum_ext[ACC_BITS-1:0];
                  end
`else
                  acc_d = acc_q + sample;
`endif
                  ovf_d   = ovf_q + CNT_BITS'(overflow);
                  cnt_d   = cnt_q + CNT_BITS'(1);
                  state_d = (cnt_d == CNT_BITS'(NUM_SAMPLES)) ? DONE : ACCUM;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_d = IDLE;
                  acc_d   = '0;
                  ovf_d   = '0;
                  cnt_d   = '0;
                  sat_d   = 1'b0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         ovf_q   <= '0;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
         sat_q   <= sat_d;
      end
   end

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Directed bench: a 24-bit/4-sample instance and a 17-bit/2-sample instance for the wrap/saturate edge.
module tb_adder_sum_accumulator;

   logic        clk = 1'b0;
   logic        n_rst;
   int          checks = 0;
   int          errors = 0;

   // Instance A: SUM_BITS=16, ACC_BITS=24, NUM_SAMPLES=4
   logic        in_valid, in_ready, overflow, clear, out_valid, out_ready, sat_flag;
   logic [15:0] sum;
   logic [23:0] acc_out;
   logic [2:0]  ovf_count;

   // Instance B: SUM_BITS=16, ACC_BITS=17, NUM_SAMPLES=2
   logic        in_valid2, in_ready2, overflow2, clear2, out_valid2, out_ready2, sat_flag2;
   logic [15:0] sum2;
   logic [16:0] acc_out2;
   logic [1:0]  ovf_count2;

   always #5 clk = ~clk;

   adder_sum_accumulator #(.SUM_BITS(16), .ACC_BITS(24), .NUM_SAMPLES(4)) dut (
      .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
      .sum(sum), .overflow(overflow), .clear(clear), .acc_out(acc_out),
      .ovf_count(ovf_count), .out_valid(out_valid), .out_ready(out_ready),
      .sat_flag(sat_flag)
   );

   adder_sum_accumulator #(.SUM_BITS(16), .ACC_BITS(17), .NUM_SAMPLES(2)) dut2 (
      .clk(clk), .n_rst(n_rst), .in_valid(in_valid2), .in_ready(in_ready2),
      .sum(sum2), .overflow(overflow2), .clear(clear2), .acc_out(acc_out2),
      .ovf_count(ovf_count2), .out_valid(out_valid2), .out_ready(out_ready2),
      .sat_flag(sat_flag2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      n_rst = 1'b0; in_valid = 1'b1; sum = 16'd5; overflow = 1'b1;
      in_valid2 = 1'b1; sum2 = 16'd5;
      step(); step();
      n_rst = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0; overflow = 1'b0;
      checks++; if (acc_out !== 24'h0) begin errors++; $display("FAIL reset_acc: got %h expected %h", acc_out, 24'h0); end
      checks++; if (ovf_count !== 3'd0) begin errors++; $display("FAIL reset_ovf: got %0d expected 0", ovf_count); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b expected 0", sat_flag); end
      checks++; if (acc_out2 !== 17'h0) begin errors++; $display("FAIL reset_acc2: got %h expected 0", acc_out2); end
   endtask

   task automatic test_basic_block();
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1'b1; sum = 16'(i); overflow = 1'b0;
         step();
         if (i == 2) begin
            checks++; if (acc_out !== 24'h3) begin errors++; $display("FAIL basic_partial: got %h expected %h", acc_out, 24'h3); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", out_valid); end
         end
      end
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid: got %b expected 1", out_valid); end
      checks++; if (acc_out !== 24'h00000A) begin errors++; $display("FAIL basic_acc: got %h expected %h", acc_out, 24'h00000A); end
      checks++; if (ovf_count !== 3'd0) begin errors++; $display("FAIL basic_ovf: got %0d expected 0", ovf_count); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready: got %b expected 0", in_ready); end
      out_ready = 1'b1; step(); out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || acc_out !== 24'h0) begin errors++; $display("FAIL basic_drain: got valid=%b acc=%h expected valid=0 acc=0", out_valid, acc_out); end
   endtask

   task automatic test_overflow_block();
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; sum = 16'hFFFF; overflow = 1'b1;
         step();
      end
      in_valid = 1'b0; overflow = 1'b0;
      checks++; if (acc_out !== 24'h07FFFC) begin errors++; $display("FAIL ovf_acc: got %h expected %h", acc_out, 24'h07FFFC); end
      checks++; if (ovf_count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", ovf_count); end
      checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL ovf_sat: got %b expected 0", sat_flag); end
   endtask

   // Continues from the DONE state left by test_overflow_block.
   task automatic test_backpressure();
      out_ready = 1'b0; in_valid = 1'b1; sum = 16'd3;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_%0d: got valid=%b ready=%b expected valid=1 ready=0", i, out_valid, in_ready); end
         checks++; if (acc_out !== 24'h07FFFC || ovf_count !== 3'd4) begin errors++; $display("FAIL bp_stable_%0d: got acc=%h ovf=%0d expected acc=07fffc ovf=4", i, acc_out, ovf_count); end
      end
      in_valid = 1'b0; out_ready = 1'b1; step(); out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", out_valid); end
      checks++; if (acc_out !== 24'h0 || ovf_count !== 3'd0) begin errors++; $display("FAIL bp_release_clear: got acc=%h ovf=%0d expected 0/0", acc_out, ovf_count); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_wrap_saturate();
      logic [16:0] exp_acc;
      logic        exp_sat;
`ifdef ADDER_SUM_ACC_SATURATE_EN
      exp_acc = 17'h1FFFF; exp_sat = 1'b1;
`else
      exp_acc = 17'h1FFFE; exp_sat = 1'b0;
`endif
      in_valid2 = 1'b1; sum2 = 16'hFFFF; overflow2 = 1'b1;
      step();
      checks++; if (acc_out2 !== 17'h1FFFF || sat_flag2 !== 1'b0) begin errors++; $display("FAIL wrap_first: got acc=%h sat=%b expected acc=1ffff sat=0", acc_out2, sat_flag2); end
      step();
      in_valid2 = 1'b0; overflow2 = 1'b0;
      checks++; if (acc_out2 !== exp_acc) begin errors++; $display("FAIL wrap_acc: got %h expected %h", acc_out2, exp_acc); end
      checks++; if (sat_flag2 !== exp_sat) begin errors++; $display("FAIL wrap_sat: got %b expected %b", sat_flag2, exp_sat); end
      checks++; if (out_valid2 !== 1'b1 || ovf_count2 !== 2'd2) begin errors++; $display("FAIL wrap_done: got valid=%b ovf=%0d expected valid=1 ovf=2", out_valid2, ovf_count2); end
      out_ready2 = 1'b1; step(); out_ready2 = 1'b0;
      checks++; if (sat_flag2 !== 1'b0 || acc_out2 !== 17'h0) begin errors++; $display("FAIL wrap_drain: got sat=%b acc=%h expected sat=0 acc=0", sat_flag2, acc_out2); end
   endtask

   task automatic test_clear();
      in_valid = 1'b1; overflow = 1'b0;
      sum = 16'd5; step();
      sum = 16'd7; step();
      checks++; if (acc_out !== 24'd12) begin errors++; $display("FAIL clear_pre: got %h expected %h", acc_out, 24'd12); end
      clear = 1'b1; sum = 16'd9; step(); clear = 1'b0;
      checks++; if (acc_out !== 24'h0 || ovf_count !== 3'd0) begin errors++; $display("FAIL clear_zero: got acc=%h ovf=%0d expected 0/0", acc_out, ovf_count); end
      sum = 16'd10; step();
      sum = 16'd20; step();
      sum = 16'd30; step();
      checks++; if (out_valid !== 1'b0 || acc_out !== 24'd60) begin errors++; $display("FAIL clear_fresh_partial: got valid=%b acc=%h expected valid=0 acc=3c", out_valid, acc_out); end
      sum = 16'd40; overflow = 1'b1; step();
      in_valid = 1'b0; overflow = 1'b0;
      checks++; if (out_valid !== 1'b1 || acc_out !== 24'h010064 || ovf_count !== 3'd1) begin errors++; $display("FAIL clear_fresh_block: got valid=%b acc=%h ovf=%0d expected valid=1 acc=010064 ovf=1", out_valid, acc_out, ovf_count); end
      clear = 1'b1; out_ready = 1'b1; step(); clear = 1'b0; out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || acc_out !== 24'h0) begin errors++; $display("FAIL clear_in_done: got valid=%b acc=%h expected valid=0 acc=0", out_valid, acc_out); end
   endtask

   task automatic test_reset_mid();
      in_valid = 1'b1; sum = 16'd100; overflow = 1'b1; step(); step();
      n_rst = 1'b0; step(); n_rst = 1'b1;
      in_valid = 1'b0; overflow = 1'b0;
      checks++; if (acc_out !== 24'h0 || ovf_count !== 3'd0) begin errors++; $display("FAIL reset_mid: got acc=%h ovf=%0d expected 0/0", acc_out, ovf_count); end
      in_valid = 1'b1; sum = 16'd1;
      for (int i = 0; i < 3; i++) step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0 || acc_out !== 24'd3) begin errors++; $display("FAIL reset_mid_count: got valid=%b acc=%h expected valid=0 acc=3", out_valid, acc_out); end
   endtask

   initial begin
      n_rst = 1'b0; in_valid = 1'b0; sum = '0; overflow = 1'b0; clear = 1'b0; out_ready = 1'b0;
      in_valid2 = 1'b0; sum2 = '0; overflow2 = 1'b0; clear2 = 1'b0; out_ready2 = 1'b0;
      #2;
      test_reset();
      test_basic_block();
      test_overflow_block();
      test_backpressure();
      test_wrap_saturate();
      test_clear();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
